// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: owner encoding, slot phase constants and default widths for the VRAM arbiter
package vram_arb_pkg;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam logic PHASE_SCAN = 1'b0;
    localparam logic PHASE_SHARED = 1'b1;
    typedef enum logic [1:0] {OWN_IDLE, OWN_VID, OWN_CPU, OWN_BLT} owner_e;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester-side and RAM-side signals of the VRAM arbiter
interface vram_arbiter_if;
    import vram_arb_pkg::*;
    logic vid_line_start, vid_req, vid_ack;
    logic cpu_req, cpu_we, cpu_ack, cpu_wait;
    logic blt_req, blt_we, blt_ack;
    logic ram_cs, ram_we;
    logic [ADDR_W-1:0] vid_addr, cpu_addr, blt_addr, ram_addr;
    logic [DATA_W-1:0] vid_rdata, cpu_wdata, cpu_rdata, blt_wdata, blt_rdata, ram_wdata, ram_rdata;
    modport master (
        output vid_line_start, vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               blt_req, blt_we, blt_addr, blt_wdata, ram_rdata,
        input  vid_ack, vid_rdata, cpu_ack, cpu_rdata, cpu_wait, blt_ack, blt_rdata,
               ram_cs, ram_we, ram_addr, ram_wdata
    );
    modport slave (
        input  vid_line_start, vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               blt_req, blt_we, blt_addr, blt_wdata, ram_rdata,
        output vid_ack, vid_rdata, cpu_ack, cpu_rdata, cpu_wait, blt_ack, blt_rdata,
               ram_cs, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vram_rr_pick.sv
// vram_rr_pick: two-way round-robin picker (a = CPU, b = BLT); last pointer moves only on a grant
module vram_rr_pick (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);
    logic last_b;
    assign gnt_a = en && req_a && (!req_b || last_b);
    assign gnt_b = en && req_b && (!req_a || !last_b);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_b <= 1'b1;
        else if (gnt_a || gnt_b)
            last_b <= gnt_b;
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: scan/shared time-slot arbiter sharing video RAM between CRT fetch, CPU and blitter.
// Define VRAM_BLANK_STEAL_EN to offer scan slots left unused by scan-out to CPU/BLT.
module vram_arbiter
    import vram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    vram_arbiter_if.slave bus
);
`ifdef VRAM_BLANK_STEAL_EN
    localparam logic STEAL = 1'b1;
`else
    localparam logic STEAL = 1'b0;
`endif
    owner_e owner, prev_owner, grant;
    logic phase, next_phase, scan_next, prev_we, rr_en;
    logic vid_ok, cpu_ok, blt_ok, gnt_cpu, gnt_blt, rd_cpu, rd_blt;
    logic [DATA_W-1:0] vid_q, cpu_q, blt_q;

    assign next_phase = bus.vid_line_start ? PHASE_SCAN : ~phase;
    assign scan_next = next_phase == PHASE_SCAN;
    // the owner of the current cycle sits out this decision so it cannot issue twice before its ACK
    assign vid_ok = bus.vid_req && owner != OWN_VID;
    assign cpu_ok = bus.cpu_req && owner != OWN_CPU;
    assign blt_ok = bus.blt_req && owner != OWN_BLT;
    assign rr_en = !scan_next || (STEAL && !vid_ok);
    assign grant = (scan_next && vid_ok) ? OWN_VID : gnt_cpu ? OWN_CPU : gnt_blt ? OWN_BLT : OWN_IDLE;

    vram_rr_pick u_pick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rr_en),
        .req_a (cpu_ok),
        .req_b (blt_ok),
        .gnt_a (gnt_cpu),
        .gnt_b (gnt_blt)
    );

    assign bus.vid_ack = prev_owner == OWN_VID;
    assign bus.cpu_ack = prev_owner == OWN_CPU;
    assign bus.blt_ack = prev_owner == OWN_BLT;
    assign rd_cpu = bus.cpu_ack && !prev_we;
    assign rd_blt = bus.blt_ack && !prev_we;
    // RAM data arrives in the ACK cycle; pass it through then, hold the captured copy otherwise
    assign bus.vid_rdata = bus.vid_ack ? bus.ram_rdata : vid_q;
    assign bus.cpu_rdata = rd_cpu ? bus.ram_rdata : cpu_q;
    assign bus.blt_rdata = rd_blt ? bus.ram_rdata : blt_q;
    assign bus.cpu_wait = rst_n && bus.cpu_req && !bus.cpu_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PHASE_SCAN;
            owner <= OWN_IDLE;
            prev_owner <= OWN_IDLE;
            prev_we <= 1'b0;
            bus.ram_cs <= 1'b0;
            bus.ram_we <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_wdata <= '0;
            vid_q <= '0;
            cpu_q <= '0;
            blt_q <= '0;
        end else begin
            phase <= next_phase;
            owner <= grant;
            prev_owner <= owner;
            prev_we <= bus.ram_we;
            bus.ram_cs <= grant != OWN_IDLE;
            bus.ram_we <= grant == OWN_CPU ? bus.cpu_we : grant == OWN_BLT ? bus.blt_we : 1'b0;
            bus.ram_addr <= grant == OWN_VID ? bus.vid_addr : grant == OWN_CPU ? bus.cpu_addr :
                            grant == OWN_BLT ? bus.blt_addr : '0;
            bus.ram_wdata <= grant == OWN_CPU ? bus.cpu_wdata : grant == OWN_BLT ? bus.blt_wdata : '0;
            if (bus.vid_ack)
                vid_q <= bus.ram_rdata;
            if (rd_cpu)
                cpu_q <= bus.ram_rdata;
            if (rd_blt)
                blt_q <= bus.ram_rdata;
        end
    end
endmodule
